// File: rtl/mult_div_unit.sv
// Iterative signed 32x32 multiplier (shift-add) and 32/32 restoring divider
// for the multi-cycle MIPS datapath; results feed HI/LO and the MUL write-back.
module mult_div_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic        mult_start,
    input  logic        div_start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] hi_result,
    output logic [31:0] lo_result,
    output logic        mult_div_done,
    output logic        busy,
    output logic        div_by_zero
);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, FIX, DONE} state_t;

    state_t      state;
    logic        is_div;
    logic        neg_res;
    logic        neg_rem;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [5:0]  iter_cnt;
    logic [63:0] prod;
    logic [31:0] rem;
    logic [31:0] quo;

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // Multiply keeps {partial product, remaining multiplier bits} in one 64-bit
    // register; divide shifts dividend bits out of quo as quotient bits shift in.
    always_comb begin
        abs_a     = op_a[31] ? (~op_a + 32'd1) : op_a;
        abs_b     = op_b[31] ? (~op_b + 32'd1) : op_b;
        mul_sum   = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mag_a} : 33'd0);
        div_shift = {rem, quo[31]};
        div_diff  = div_shift - {1'b0, mag_b};
        prod_fix  = neg_res ? (~prod + 64'd1) : prod;
        quo_fix   = neg_res ? (~quo + 32'd1) : quo;
        rem_fix   = neg_rem ? (~rem + 32'd1) : rem;
    end

    assign busy          = (state != IDLE);
    assign mult_div_done = (state == DONE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            is_div      <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            mag_a       <= 32'd0;
            mag_b       <= 32'd0;
            iter_cnt    <= 6'd0;
            prod        <= 64'd0;
            rem         <= 32'd0;
            quo         <= 32'd0;
            hi_result   <= 32'd0;
            lo_result   <= 32'd0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mult_start || div_start) begin
                        is_div      <= !mult_start;
                        div_by_zero <= 1'b0;
                        state       <= LOAD;
                    end
                end

                // Operands come from the A/B registers, valid one cycle after decode.
                LOAD: begin
                    mag_a    <= abs_a;
                    mag_b    <= abs_b;
                    neg_res  <= op_a[31] ^ op_b[31];
                    neg_rem  <= op_a[31];
                    iter_cnt <= 6'd0;
                    prod     <= {32'd0, abs_b};
                    rem      <= 32'd0;
                    quo      <= abs_a;
                    if (is_div && (op_b == 32'd0)) begin
                        div_by_zero <= 1'b1;
                        hi_result   <= op_a;
                        lo_result   <= 32'hFFFF_FFFF;
                        state       <= DONE;
                    end else begin
                        state <= RUN;
                    end
                end

                RUN: begin
                    if (is_div) begin
                        if (!div_diff[32]) begin
                            rem <= div_diff[31:0];
                            quo <= {quo[30:0], 1'b1};
                        end else begin
                            rem <= div_shift[31:0];
                            quo <= {quo[30:0], 1'b0};
                        end
                    end else begin
                        prod <= {mul_sum, prod[31:1]};
                    end
                    iter_cnt <= iter_cnt + 6'd1;
                    if (iter_cnt == 6'd31) begin
                        state <= FIX;
                    end
                end

                // Remainder follows the dividend's sign, quotient/product the XOR.
                FIX: begin
                    if (is_div) begin
                        hi_result <= rem_fix;
                        lo_result <= quo_fix;
                    end else begin
                        hi_result <= prod_fix[63:32];
                        lo_result <= prod_fix[31:0];
                    end
                    state <= DONE;
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// operations compared against a signed 64-bit arithmetic reference model.
module tb_mult_div_unit;

    logic        CLK;
    logic        RST;
    logic        mult_start;
    logic        div_start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] hi_result;
    logic [31:0] lo_result;
    logic        mult_div_done;
    logic        busy;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    mult_div_unit dut (
        .CLK           (CLK),
        .RST           (RST),
        .mult_start    (mult_start),
        .div_start     (div_start),
        .op_a          (op_a),
        .op_b          (op_b),
        .hi_result     (hi_result),
        .lo_result     (lo_result),
        .mult_div_done (mult_div_done),
        .busy          (busy),
        .div_by_zero   (div_by_zero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: plain signed 64-bit arithmetic (truncating divide, remainder
    // takes the dividend's sign), divide by zero returns {a, all ones}.
    function automatic void model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output bit dz);
        longint sa;
        longint sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        if (!is_div) begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
            dz = 1'b1;
        end else begin
            p  = sa % sb;
            hi = p[31:0];
            p  = sa / sb;
            lo = p[31:0];
        end
    endfunction

    // Launch one operation on a negedge (cycle 0) and follow it to done,
    // optionally firing stray start pulses at two later cycles.
    task automatic applyStimulus(input bit do_mul, input bit do_div,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input int inj1, input int inj2,
                                 output int done_cyc, output bit busy_ok,
                                 output logic [31:0] hi_d, output logic [31:0] lo_d,
                                 output logic dz_d);
        @(negedge CLK);
        op_a       = a;
        op_b       = b;
        mult_start = do_mul;
        div_start  = do_div;
        done_cyc   = -1;
        busy_ok    = (busy === 1'b0) && (mult_div_done === 1'b0);
        hi_d = 32'hx; lo_d = 32'hx; dz_d = 1'bx;
        for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
            @(negedge CLK);
            mult_start = 1'b0;
            div_start  = 1'b0;
            if (c == inj1 || c == inj2) begin
                mult_start = 1'b1;
                div_start  = 1'b1;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (mult_div_done === 1'b1) begin
                done_cyc = c;
                hi_d     = hi_result;
                lo_d     = lo_result;
                dz_d     = div_by_zero;
            end
        end
        mult_start = 1'b0;
        div_start  = 1'b0;
    endtask

    // Run one operation and compare latency, busy window and results with the model.
    task automatic run_checked(input string name, input bit is_div,
                               input logic [31:0] a, input logic [31:0] b);
        int          dc;
        bit          bok;
        logic [31:0] hd, ld, eh, el;
        logic        dzd;
        bit          edz;
        int          ecyc;
        model(is_div, a, b, eh, el, edz);
        ecyc = edz ? 2 : 35;
        applyStimulus(!is_div, is_div, a, b, -1, -1, dc, bok, hd, ld, dzd);
        checks++;
        if (dc != ecyc) begin errors++; $display("[TB] FAIL %s done_cycle got=%0d exp=%0d", name, dc, ecyc); end
        checks++;
        if (!bok) begin errors++; $display("[TB] FAIL %s busy_window got=0 exp=1", name); end
        checks++;
        if (hd !== eh) begin errors++; $display("[TB] FAIL %s hi got=%h exp=%h", name, hd, eh); end
        checks++;
        if (ld !== el) begin errors++; $display("[TB] FAIL %s lo got=%h exp=%h", name, ld, el); end
        checks++;
        if (dzd !== edz) begin errors++; $display("[TB] FAIL %s dz got=%b exp=%b", name, dzd, edz); end
    endtask

    task automatic test_reset;
        RST = 1'b0; mult_start = 1'b0; div_start = 1'b0; op_a = 32'd0; op_b = 32'd0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({hi_result, lo_result, mult_div_done, busy, div_by_zero} !== 67'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got=%h/%h/%b%b%b exp=0", hi_result, lo_result, mult_div_done, busy, div_by_zero);
        end
        RST = 1'b1;
    endtask

    task automatic test_mult_directed;
        logic [31:0] hd, ld; logic dzd; int dc; bit bok;
        applyStimulus(1'b1, 1'b0, 32'd7, 32'd6, -1, -1, dc, bok, hd, ld, dzd);
        checks++;
        if (dc != 35) begin errors++; $display("[TB] FAIL mul7x6_cycle got=%0d exp=35", dc); end
        checks++;
        if (!bok) begin errors++; $display("[TB] FAIL mul7x6_busy got=0 exp=1"); end
        checks++;
        if ({hd, ld} !== 64'h0000_0000_0000_002A) begin errors++; $display("[TB] FAIL mul7x6_result got=%h%h exp=000000000000002a", hd, ld); end
        applyStimulus(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd5, -1, -1, dc, bok, hd, ld, dzd);
        checks++;
        if ({hd, ld} !== 64'hFFFF_FFFF_FFFF_FFF1) begin errors++; $display("[TB] FAIL mul_m3x5 got=%h%h exp=fffffffffffffff1", hd, ld); end
        applyStimulus(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, -1, -1, dc, bok, hd, ld, dzd);
        checks++;
        if ({hd, ld} !== 64'h4000_0000_0000_0000) begin errors++; $display("[TB] FAIL mul_min_sq got=%h%h exp=4000000000000000", hd, ld); end
    endtask

    task automatic test_div_directed;
        logic [31:0] hd, ld; logic dzd; int dc; bit bok;
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, -1, -1, dc, bok, hd, ld, dzd);
        checks++;
        if ({hd, ld} !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("[TB] FAIL div_m7_2 got=%h/%h exp=ffffffff/fffffffd", hd, ld); end
        applyStimulus(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, dc, bok, hd, ld, dzd);
        checks++;
        if ({hd, ld, dzd} !== {32'd0, 32'h8000_0000, 1'b0}) begin errors++; $display("[TB] FAIL div_min_m1 got=%h/%h/%b exp=00000000/80000000/0", hd, ld, dzd); end
    endtask

    task automatic test_div_by_zero;
        logic [31:0] hd, ld; logic dzd; int dc; bit bok;
        applyStimulus(1'b0, 1'b1, 32'd5, 32'd0, -1, -1, dc, bok, hd, ld, dzd);
        checks++;
        if (dc != 2) begin errors++; $display("[TB] FAIL dz_cycle got=%0d exp=2", dc); end
        checks++;
        if ({hd, ld, dzd} !== {32'd5, 32'hFFFF_FFFF, 1'b1}) begin errors++; $display("[TB] FAIL dz_result got=%h/%h/%b exp=00000005/ffffffff/1", hd, ld, dzd); end
        @(negedge CLK);
        checks++;
        if (div_by_zero !== 1'b1) begin errors++; $display("[TB] FAIL dz_hold got=%b exp=1", div_by_zero); end
        applyStimulus(1'b1, 1'b0, 32'd3, 32'd3, -1, -1, dc, bok, hd, ld, dzd);
        checks++;
        if ({ld, dzd} !== {32'd9, 1'b0}) begin errors++; $display("[TB] FAIL dz_clear got=%h/%b exp=00000009/0", ld, dzd); end
    endtask

    task automatic test_ignored_starts;
        logic [31:0] hd, ld; logic dzd; int dc; bit bok;
        applyStimulus(1'b1, 1'b0, 32'd3, 32'd4, 10, 20, dc, bok, hd, ld, dzd);
        checks++;
        if (dc != 35 || ld !== 32'd12) begin errors++; $display("[TB] FAIL stray_starts got=%0d/%h exp=35/0000000c", dc, ld); end
        applyStimulus(1'b1, 1'b1, 32'd2, 32'd9, -1, -1, dc, bok, hd, ld, dzd);
        checks++;
        if ({hd, ld, dzd} !== {32'd0, 32'd18, 1'b0}) begin errors++; $display("[TB] FAIL both_starts got=%h/%h/%b exp=00000000/00000012/0", hd, ld, dzd); end
    endtask

    task automatic test_reset_mid_op;
        @(negedge CLK);
        op_a = 32'd1000; op_b = 32'd3; div_start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge CLK);
            div_start = 1'b0;
        end
        RST = 1'b0;
        #1;
        checks++;
        if ({hi_result, lo_result, mult_div_done, busy, div_by_zero} !== 67'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_op got=%h/%h/%b%b%b exp=0", hi_result, lo_result, mult_div_done, busy, div_by_zero);
        end
        @(negedge CLK);
        RST = 1'b1;
        run_checked("div_after_reset", 1'b1, 32'd100, 32'd7);
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: b = $urandom_range(1, 20);
                default: ;
            endcase
            run_checked($sformatf("rand%0d", i), i[0], a, b);
        end
    endtask

    task automatic test_back_to_back;
        run_checked("b2b_first", 1'b0, 32'hFFFF_0001, 32'h0001_2345);
        run_checked("b2b_second", 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFF0);
    endtask

    task automatic checkOutput;
        $display("Result: errors=%0d of %0d checks", errors, checks);
    endtask

    initial begin
        test_reset();
        test_mult_directed();
        test_div_directed();
        test_div_by_zero();
        test_ignored_starts();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        checkOutput();
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative signed 32x32 multiplier and 32/32 divider serving the multi-cycle MIPS datapath. Launched by the sequence controller's one-cycle `mult_start` / `div_start` pulse, issued in the decode state. While it runs, the controller waits in its mult/div wait state, polling `mult_div_done`. On `mult_div_done` the controller moves to its HI/LO load state (mult/div), or the result write-back state (MUL). Results feed the HI/LO register inputs (`hi_SEL`/`lo_SEL` = 1) and the MUL write-back path.

## Interface
- No parameters; datapath width fixed at 32.
- `CLK`  in  1  clock; reset `RST` is asynchronous, active-low.
- `RST`  in  1  asynchronous active-low reset.
- `mult_start`  in  1  one-cycle pulse: start signed multiply (MULT and MUL).
- `div_start`  in  1  one-cycle pulse: start signed divide (DIV).
- `op_a`  in  32  rs operand (A register); multiplicand / dividend.
- `op_b`  in  32  rt operand (B register); multiplier / divisor.
- `hi_result`  out  32  mult: product[63:32]; div: remainder.
- `lo_result`  out  32  mult: product[31:0]; div: quotient.
- `mult_div_done`  out  1  high exactly one cycle when results are valid.
- `busy`  out  1  high from the cycle after a start until `mult_div_done` inclusive.
- `div_by_zero`  out  1  set with done when a divide had `op_b`=0; held until next start.

## Operation
- States: IDLE, LOAD, RUN, FIX, DONE.
- IDLE: `busy`=0. Accept a start here only.
  - Record op type on the start cycle; `mult_start` wins if both starts are high.
  - Go to LOAD.
- LOAD: sample `op_a`/`op_b`. The A/B registers are valid in the cycle after decode.
  - Store operand magnitudes, result sign, dividend sign; clear iteration counter (6 bits).
  - Divide with `op_b`=0: set `div_by_zero`, hi_result=`op_a`, lo_result=32'hFFFFFFFF, go to DONE.
  - Otherwise go to RUN.
- RUN: 32 iterations, one per cycle; counter 0..31; after iteration 31 go to FIX.
  - Multiply: radix-2 shift-add on unsigned magnitudes into a 64-bit accumulator.
  - Divide: restoring division. Shift the 33-bit partial remainder left, bringing in the next dividend bit. Subtract the divisor; on non-negative result keep it and set the quotient bit to 1, else restore and set it to 0.
- FIX: apply signs (two's-complement negate).
  - Product negated if a[31]^b[31].
  - Quotient negated if a[31]^b[31].
  - Remainder negated if a[31] (remainder takes the dividend's sign).
  - Load `hi_result`/`lo_result`; go to DONE.
- DONE: `mult_div_done`=1 for this cycle only; go to IDLE.
- Results and `div_by_zero` hold their values until the next accepted start.
  - The MUL write-back state reads them the cycle after done.
- 0x80000000 / -1: quotient 0x80000000, remainder 0; no flag.
- Starts arriving in LOAD/RUN/FIX/DONE are ignored; the operation in progress is unaffected.
- Reset, including mid-operation: state IDLE, counter 0.
  - `hi_result`=0, `lo_result`=0, `mult_div_done`=0, `busy`=0, `div_by_zero`=0.
  - The in-flight operation is discarded.

## Timing
- Cycle 0: start high (controller in decode).
- Cycle 1: LOAD.
- Cycles 2–33: RUN.
- Cycle 34: FIX.
- Cycle 35: DONE, `mult_div_done`=1.
- Normal latency: 35 cycles start-to-done.
- Divide by zero: DONE at cycle 2.
- `busy` high on cycles 1..done.
- Controller sees done in its wait state and moves to HI/LO load / MUL write-back at cycle 36.
- Outputs `hi_result`, `lo_result`, `div_by_zero` are registered and stable from the done cycle onward.
- `mult_div_done` and `busy` are decoded from the state register.
- Back-to-back: a new start is accepted in the first IDLE cycle after DONE.

## Test plan
- mult 7 × 6 -> done exactly at cycle 35; hi=0x00000000, lo=0x0000002A; `busy` high cycles 1–35.
- mult −3 × 5, and 0x80000000 × 0x80000000:
  - −3 × 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0x00000000.
- div −7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- div 5 / 0 -> done at cycle 2; hi=0x00000005, lo=0xFFFFFFFF, `div_by_zero`=1. A following mult clears the flag.
- start pulses on cycles 10 and 20 of a running mult 3 × 4 -> ignored; done still at 35, lo=12. Both starts high with 2, 9 -> multiply, lo=18.
- RST low at cycle 15 of a divide -> all outputs 0 immediately. After release, a new div 100 / 7 -> lo=14, hi=2 at cycle 35 from its start.
